dsp_decimating_output_buffer: RTL

- Downstream neighbour of the main DSP pipeline: consumes its output sample stream (data word plus valid strobe, no backpressure).
- Applies programmable integer decimation, either pick-first or accumulate-and-dump with signed saturation.
- Buffers results in a small show-ahead FIFO that drives a ready/valid output stream toward the host/capture side.
- Exports drop and saturation counters for debug.

---
 rtl/dsp_decimating_output_buffer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/dsp_decimating_output_buffer.sv
// dsp_decimating_output_buffer
// Decimates the DSP pipeline output stream (pick-first or saturating
// accumulate-and-dump over a programmable window) and buffers the results
// in a show-ahead FIFO that feeds a ready/valid stream to the host side.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   enable              accept input samples when high; window state held when low
//   flush               one-cycle pulse, discards the partial window (FIFO untouched)
//   dump_mode           0 = pick first sample of window, 1 = saturated window sum
//   decimation_factor   window length N (0 behaves as 1), sampled at window start
//   data_in/valid_in    input sample stream, no backpressure
//   out_data/out_valid  FIFO head / FIFO non-empty
//   out_ready           consumer handshake; pop on out_valid & out_ready
//   fifo_level          FIFO occupancy
//   window_count        samples accepted in the current window
//   drop_count          results lost to a full FIFO (saturating)
//   sat_count           results clipped by saturation (saturating)
module dsp_decimating_output_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 48,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          flush,
  input  logic                          dump_mode,
  input  logic [15:0]                   decimation_factor,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          data_valid_in,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   window_count,
  output logic [CNT_WIDTH-1:0]          drop_count,
  output logic [CNT_WIDTH-1:0]          sat_count
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned LW     = AW + 1;
  localparam int unsigned EXT_W  = ACC_WIDTH - DATA_WIDTH;
  localparam int unsigned HI_W   = ACC_WIDTH - DATA_WIDTH + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Window state
  logic [0:0]            state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [15:0]           wc_q, wc_d;
  logic [15:0]           n_eff_q, n_eff_d;
  logic                  mode_q, mode_d;

  // FIFO and counters
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [CNT_WIDTH-1:0]  drop_q, drop_d;
  logic [CNT_WIDTH-1:0]  sat_q, sat_d;

  // Combinational helpers
  logic                  accept_c;
  logic [ACC_WIDTH-1:0]  data_ext_c;
  logic [ACC_WIDTH-1:0]  sum_c;
  logic [HI_W-1:0]       sum_hi_c;
  logic                  clip_c;
  logic [DATA_WIDTH-1:0] sat_val_c;
  logic [15:0]           n_new_c;
  logic [15:0]           wc_inc_c;
  logic                  push_c;
  logic                  clip_evt_c;
  logic [DATA_WIDTH-1:0] result_c;
  logic                  pop_c;
  logic                  full_c;
  logic                  wr_en_c;
  logic                  drop_evt_c;

  assign accept_c   = data_valid_in & enable & ~flush;
  assign data_ext_c = {{EXT_W{data_in[DATA_WIDTH-1]}}, data_in};
  assign sum_c      = acc_q + data_ext_c;
  // Sum fits in DATA_WIDTH only if all bits from the DATA_WIDTH sign bit up agree
  assign sum_hi_c   = sum_c[ACC_WIDTH-1:DATA_WIDTH-1];
  assign clip_c     = ~((&sum_hi_c) | ~(|sum_hi_c));
  assign sat_val_c  = clip_c ? (sum_c[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX)
                             : sum_c[DATA_WIDTH-1:0];
  assign n_new_c    = (decimation_factor == 16'd0) ? 16'd1 : decimation_factor;
  assign wc_inc_c   = wc_q + 16'd1;

  // Window FSM: next state and completed-window result
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    wc_d       = wc_q;
    n_eff_d    = n_eff_q;
    mode_d     = mode_q;
    push_c     = 1'b0;
    clip_evt_c = 1'b0;
    result_c   = '0;
    if (flush) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      wc_d    = '0;
    end else if (accept_c) begin
      case (state_q)
        ST_IDLE: begin
          n_eff_d = n_new_c;
          mode_d  = dump_mode;
          if (n_new_c == 16'd1) begin
            // Single-sample window: result is the sample itself in both modes
            push_c   = 1'b1;
            result_c = data_in;
            acc_d    = '0;
            wc_d     = '0;
          end else begin
            state_d = ST_ACCUM;
            acc_d   = data_ext_c;
            wc_d    = 16'd1;
          end
        end
        ST_ACCUM: begin
          if (wc_inc_c == n_eff_q) begin
            push_c = 1'b1;
            if (mode_q) begin
              result_c   = sat_val_c;
              clip_evt_c = clip_c;
            end else begin
              result_c = acc_q[DATA_WIDTH-1:0];
            end
            state_d = ST_IDLE;
            acc_d   = '0;
            wc_d    = '0;
          end else begin
            wc_d = wc_inc_c;
            if (mode_q) acc_d = sum_c;
          end
        end
        default: begin
          state_d = ST_IDLE;
          acc_d   = '0;
          wc_d    = '0;
        end
      endcase
    end
  end

  assign pop_c      = out_valid & out_ready;
  assign full_c     = (level_q == LW'(FIFO_DEPTH));
  // A full FIFO still accepts a push when the head leaves on the same edge
  assign wr_en_c    = push_c & (~full_c | pop_c);
  assign drop_evt_c = push_c & full_c & ~pop_c;

  // FIFO storage, pointers, occupancy and debug counters
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    sat_d    = sat_q;
    if (wr_en_c) begin
      mem_d[wr_ptr_q] = result_c;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en_c, pop_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (drop_evt_c && (drop_q != '1)) drop_d = drop_q + CNT_WIDTH'(1);
    if (clip_evt_c && (sat_q != '1))  sat_d  = sat_q + CNT_WIDTH'(1);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      wc_q     <= '0;
      n_eff_q  <= 16'd1;
      mode_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      sat_q    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      wc_q     <= wc_d;
      n_eff_q  <= n_eff_d;
      mode_q   <= mode_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
      sat_q    <= sat_d;
      mem_q    <= mem_d;
    end
  end

  assign out_data     = mem_q[rd_ptr_q];
  assign out_valid    = (level_q != '0);
  assign fifo_level   = level_q;
  assign window_count = wc_q;
  assign drop_count   = drop_q;
  assign sat_count    = sat_q;

endmodule
